// File: rtl/mdio_rd_pkg.sv
// Shared definitions for the MDIO read engine: FSM state encoding and the
// width helper used to size the lane-select and bank-index fields.
package mdio_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Field width that never collapses to zero bits.
    function automatic int width_of(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/mdio_lane_mux.sv
// Combinational bank/lane select: picks one bank word out of the flattened
// memory read bus, then one LANE_W slice out of that word.
module mdio_lane_mux
    import mdio_rd_pkg::*;
#(
    parameter int NUM_BANKS = 24,
    parameter int WORD_W    = 36,
    parameter int LANE_W    = 9,
    localparam int LANES    = WORD_W / LANE_W,
    localparam int BANK_W   = width_of(NUM_BANKS),
    localparam int LSEL_W   = width_of(LANES)
) (
    input  logic [NUM_BANKS*WORD_W-1:0] din_i,
    input  logic [BANK_W-1:0]           bank_i,
    input  logic [LSEL_W-1:0]           lane_i,
    output logic [LANE_W-1:0]           lane_o
);

    logic [WORD_W-1:0] word;

    // Two-level select: bank word first, then the lane slice within it.
    always_comb begin
        word   = '0;
        lane_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_i == BANK_W'(b)) word = din_i[b*WORD_W +: WORD_W];
        end
        for (int l = 0; l < LANES; l++) begin
            if (lane_i == LSEL_W'(l)) lane_o = word[l*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/mdio_rd_engine.sv
// Burst read engine: issues len+1 consecutive word reads to one memory bank,
// then returns the selected lane of each word, one per cycle, after the
// memory read latency. Out-of-range lane selects are rejected with rd_err.
//
// Handshake: rd_req is a single-cycle start pulse, honoured only in IDLE.
// rd_valid qualifies rd_data for exactly one cycle per word (no back-pressure);
// rd_done marks the last word of a burst (or accompanies rd_err on a reject).
module mdio_rd_engine
    import mdio_rd_pkg::*;
#(
    parameter int NUM_BANKS = 24,
    parameter int WORD_W    = 36,
    parameter int LANE_W    = 9,
    parameter int ADDR_W    = 15,
    parameter int RD_LAT    = 1,
    parameter int LEN_W     = 4,
    localparam int LANES    = WORD_W / LANE_W,
    localparam int SEL_W    = clog2(NUM_BANKS * LANES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_req,
    input  logic [SEL_W-1:0]            rd_sel,
    input  logic [ADDR_W-1:0]           rd_addr,
    input  logic [LEN_W-1:0]            rd_len,
    output logic [NUM_BANKS-1:0]        mem_chip_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [NUM_BANKS*WORD_W-1:0] mem_din,
    output logic [LANE_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        rd_done,
    output logic                        rd_err,
    output logic                        rd_busy
);

    localparam int TOTAL  = NUM_BANKS * LANES;
    localparam int BANK_W = width_of(NUM_BANKS);
    localparam int LSEL_W = width_of(LANES);

    rd_state_e              state_q;
    logic [BANK_W-1:0]      bank_q;
    logic [LSEL_W-1:0]      lane_q;
    logic [LEN_W-1:0]       cnt_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [NUM_BANKS-1:0]   chip_en_q;
    logic [RD_LAT-1:0]      vpipe_q;
    logic [RD_LAT-1:0]      lpipe_q;
    logic [LANE_W-1:0]      rd_data_q;
    logic                   rd_valid_q;
    logic                   rd_done_q;
    logic                   rd_err_q;

    logic [31:0]            sel_ext;
    logic                   sel_ok;
    logic                   bad_req;
    logic [BANK_W-1:0]      req_bank;
    logic [LSEL_W-1:0]      req_lane;
    logic                   issue;
    logic                   issue_last;
    logic [LANE_W-1:0]      lane_data;

    assign sel_ext    = 32'(rd_sel);
    assign sel_ok     = sel_ext < 32'(TOTAL);
    assign bad_req    = (state_q == IDLE) && rd_req && !sel_ok;
    assign req_bank   = BANK_W'(sel_ext / 32'(LANES));
    assign req_lane   = LSEL_W'(sel_ext % 32'(LANES));
    assign issue      = (state_q == ISSUE);
    assign issue_last = issue && (cnt_q == '0);

    mdio_lane_mux #(
        .NUM_BANKS (NUM_BANKS),
        .WORD_W    (WORD_W),
        .LANE_W    (LANE_W)
    ) u_lane_mux (
        .din_i  (mem_din),
        .bank_i (bank_q),
        .lane_i (lane_q),
        .lane_o (lane_data)
    );

    // Burst FSM: latch request, drive one address per ISSUE cycle, wait out the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bank_q    <= '0;
            lane_q    <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            chip_en_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req && sel_ok) begin
                        bank_q    <= req_bank;
                        lane_q    <= req_lane;
                        cnt_q     <= rd_len;
                        addr_q    <= rd_addr;
                        chip_en_q <= NUM_BANKS'(1) << req_bank;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_q == '0) begin
                        chip_en_q <= '0;
                        addr_q    <= '0;
                        state_q   <= DRAIN;
                    end else begin
                        cnt_q  <= cnt_q - LEN_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Leave on the edge that ends the final rd_done cycle.
                    if (rd_done_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid/last shift register tracks each issued word to its sampling cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q    <= '0;
            lpipe_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            vpipe_q[0] <= issue;
            lpipe_q[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
                lpipe_q[i] <= lpipe_q[i-1];
            end
            rd_valid_q <= vpipe_q[RD_LAT-1];
            rd_data_q  <= vpipe_q[RD_LAT-1] ? lane_data : '0;
            rd_done_q  <= lpipe_q[RD_LAT-1] | bad_req;
            rd_err_q   <= bad_req;
        end
    end

    assign mem_chip_en = chip_en_q;
    assign mem_addr    = addr_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_done     = rd_done_q;
    assign rd_err      = rd_err_q;
    assign rd_busy     = (state_q != IDLE);

endmodule
